// File: rtl/serial_linear_accumulator_if.sv
// Bus between the slice scheduler (master) and the serial linear accumulator (slave).
// Carries the clock enable, the slice handshake, the static layer parameters and the
// registered layer results with their status flags.
interface serial_linear_accumulator_if #(
   parameter int PRECISION      = 8,
   parameter int TEMP           = 4,
   parameter int BIAS_PRECISION = 32,
   parameter int NUM_FEATURES   = 2,
   parameter int N              = 16,
   parameter int M              = 8
);
   localparam int SLICE = N / TEMP;

   logic                             ce;
   logic                             slice_valid;
   logic signed [PRECISION-1:0]      features_sliced [NUM_FEATURES][SLICE];
   logic signed [PRECISION-1:0]      weights         [M][N];
   logic signed [BIAS_PRECISION-1:0] bias            [M];
   logic signed [BIAS_PRECISION-1:0] result          [NUM_FEATURES][M];
   logic                             out_valid;
   logic                             busy;
   logic                             overrun;

   modport master (
      output ce, slice_valid, features_sliced, weights, bias,
      input  result, out_valid, busy, overrun
   );

   modport slave (
      input  ce, slice_valid, features_sliced, weights, bias,
      output result, out_valid, busy, overrun
   );
endinterface

// File: rtl/serial_linear_accumulator.sv
// Serial linear layer: accumulates TEMP slices (highest slice index first), one output
// neuron per cycle for every feature lane, then adds the bias and publishes the signed
// result vector together with a one-cycle out_valid strobe.
module serial_linear_accumulator #(
   parameter int PRECISION      = 8,
   parameter int TEMP           = 4,
   parameter int BIAS_PRECISION = 32,
   parameter int NUM_FEATURES   = 2,
   parameter int N              = 16,
   parameter int M              = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   serial_linear_accumulator_if.slave   bus
);
   localparam int SLICE = N / TEMP;
   localparam int PW    = 2 * PRECISION;
   localparam int K_W   = (TEMP > 1) ? $clog2(TEMP) : 1;
   localparam int J_W   = (M > 1) ? $clog2(M) : 1;
   localparam int N_W   = (N > 1) ? $clog2(N) : 1;
   localparam logic [K_W-1:0] K_FIRST = K_W'(TEMP - 1);
   localparam logic [J_W-1:0] J_LAST  = J_W'(M - 1);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_MAC        = 2'd1,
      ST_WAIT_SLICE = 2'd2,
      ST_BIAS       = 2'd3
   } state_e;

   state_e                           state_q, state_d;
   logic [K_W-1:0]                   k_q, k_d;
   logic [J_W-1:0]                   j_q, j_d;
   logic signed [PRECISION-1:0]      slice_q  [NUM_FEATURES][SLICE];
   logic signed [PRECISION-1:0]      slice_d  [NUM_FEATURES][SLICE];
   logic signed [BIAS_PRECISION-1:0] acc_q    [NUM_FEATURES][M];
   logic signed [BIAS_PRECISION-1:0] acc_d    [NUM_FEATURES][M];
   logic signed [BIAS_PRECISION-1:0] result_q [NUM_FEATURES][M];
   logic signed [BIAS_PRECISION-1:0] result_d [NUM_FEATURES][M];
   logic                             out_valid_q, out_valid_d;
   logic                             busy_q, busy_d;
   logic                             overrun_q, overrun_d;
   logic signed [BIAS_PRECISION-1:0] p_s      [NUM_FEATURES];

   // Full-width signed product, sign-extended to the accumulator width.
   function automatic logic signed [BIAS_PRECISION-1:0] prod_ext(
      input logic signed [PRECISION-1:0] a,
      input logic signed [PRECISION-1:0] b
   );
      logic signed [PW-1:0] a_w;
      logic signed [PW-1:0] b_w;
      logic signed [PW-1:0] pr;
      a_w = PW'(a);
      b_w = PW'(b);
      pr  = a_w * b_w;
      return BIAS_PRECISION'(pr);
   endfunction

   // Partial dot product of the held slice with weight row j over the current slice window.
   always_comb begin : dot_comb
      logic [N_W-1:0] base_s;
      base_s = N_W'(k_q) * N_W'(SLICE);
      for (int f = 0; f < NUM_FEATURES; f++) begin
         p_s[f] = '0;
         for (int i = 0; i < SLICE; i++) begin
            p_s[f] = p_s[f] + prod_ext(slice_q[f][i], bus.weights[j_q][base_s + N_W'(i)]);
         end
      end
   end

   // Next-state logic: slice capture, per-neuron accumulation, bias add and status flags.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      j_d         = j_q;
      slice_d     = slice_q;
      acc_d       = acc_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      overrun_d   = overrun_q;
      if (bus.ce) begin
         out_valid_d = 1'b0;
         case (state_q)
            ST_IDLE, ST_WAIT_SLICE: begin
               if (bus.slice_valid) begin
                  slice_d = bus.features_sliced;
                  j_d     = '0;
                  state_d = ST_MAC;
               end else begin
                  state_d = state_q;
               end
            end
            ST_MAC: begin
               // A slice arriving while the MAC is still running is lost.
               if (bus.slice_valid) begin
                  overrun_d = 1'b1;
               end else begin
                  overrun_d = overrun_q;
               end
               // The first slice of a frame overwrites, so no clear cycle is needed.
               for (int f = 0; f < NUM_FEATURES; f++) begin
                  if (k_q == K_FIRST) begin
                     acc_d[f][j_q] = p_s[f];
                  end else begin
                     acc_d[f][j_q] = acc_q[f][j_q] + p_s[f];
                  end
               end
               if (j_q == J_LAST) begin
                  j_d = '0;
                  if (k_q == '0) begin
                     state_d = ST_BIAS;
                  end else begin
                     k_d     = k_q - K_W'(1);
                     state_d = ST_WAIT_SLICE;
                  end
               end else begin
                  j_d = j_q + J_W'(1);
               end
            end
            ST_BIAS: begin
               for (int f = 0; f < NUM_FEATURES; f++) begin
                  for (int j = 0; j < M; j++) begin
                     result_d[f][j] = acc_q[f][j] + bus.bias[j];
                  end
               end
               out_valid_d = 1'b1;
               k_d         = K_FIRST;
               state_d     = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
         busy_d = (state_d == ST_MAC) || (state_d == ST_BIAS);
      end else begin
         state_d = state_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         k_q         <= K_FIRST;
         j_q         <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int f = 0; f < NUM_FEATURES; f++) begin
            for (int i = 0; i < SLICE; i++) begin
               slice_q[f][i] <= '0;
            end
            for (int j = 0; j < M; j++) begin
               acc_q[f][j]    <= '0;
               result_q[f][j] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         j_q         <= j_d;
         slice_q     <= slice_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.result    = result_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_linear_accumulator.sv
// Bench for serial_linear_accumulator: directed frames from the test plan plus random
// frames, checked against a full-vector dot-product reference model.
module tb_serial_linear_accumulator;
   localparam int PRECISION      = 8;
   localparam int TEMP           = 4;
   localparam int BIAS_PRECISION = 32;
   localparam int NUM_FEATURES   = 2;
   localparam int N              = 16;
   localparam int M              = 8;
   localparam int SLICE          = N / TEMP;

   logic clk = 1'b0;
   logic rst;

   serial_linear_accumulator_if #(
      .PRECISION(PRECISION), .TEMP(TEMP), .BIAS_PRECISION(BIAS_PRECISION),
      .NUM_FEATURES(NUM_FEATURES), .N(N), .M(M)
   ) sla_if ();

   serial_linear_accumulator #(
      .PRECISION(PRECISION), .TEMP(TEMP), .BIAS_PRECISION(BIAS_PRECISION),
      .NUM_FEATURES(NUM_FEATURES), .N(N), .M(M)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (sla_if)
   );

   // Clock generation.
   always #5 clk = ~clk;

   int x [NUM_FEATURES][N];
   int w [M][N];
   int b [M];
   int exp_r [NUM_FEATURES][M];
   int n_checks  = 0;
   int n_errors  = 0;
   int cyc       = 0;
   int ov_count  = 0;
   int ov_cyc    = -1;

   // Cycle counter.
   always @(posedge clk) cyc <= cyc + 1;

   // Records every cycle in which out_valid is seen high.
   always @(negedge clk) begin
      if (sla_if.out_valid === 1'b1) begin
         ov_count = ov_count + 1;
         ov_cyc   = cyc;
      end
   end

   task automatic check_val(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] expv);
      n_checks = n_checks + 1;
      if (obs !== expv) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: whole-vector dot product plus bias, 32-bit wrapping arithmetic.
   task automatic compute_expected();
      for (int f = 0; f < NUM_FEATURES; f++) begin
         for (int j = 0; j < M; j++) begin
            int s;
            s = b[j];
            for (int n = 0; n < N; n++) s = s + x[f][n] * w[j][n];
            exp_r[f][j] = s;
         end
      end
   endtask

   task automatic apply_params();
      for (int j = 0; j < M; j++) begin
         for (int n = 0; n < N; n++) sla_if.weights[j][n] = 8'(w[j][n]);
         sla_if.bias[j] = b[j];
      end
   endtask

   task automatic set_unit();
      for (int f = 0; f < NUM_FEATURES; f++)
         for (int n = 0; n < N; n++) x[f][n] = 1;
      for (int j = 0; j < M; j++) begin
         for (int n = 0; n < N; n++) w[j][n] = 1;
         b[j] = 0;
      end
      apply_params();
   endtask

   task automatic set_random();
      for (int f = 0; f < NUM_FEATURES; f++)
         for (int n = 0; n < N; n++) x[f][n] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < M; j++) begin
         for (int n = 0; n < N; n++) w[j][n] = int'($urandom_range(0, 255)) - 128;
         b[j] = int'($urandom);
      end
      apply_params();
   endtask

   // Sends n_sl slices gap cycles apart; optional extra strobe (ov_s) or ce stall (stall_s).
   task automatic send_frame(input int n_sl, input int gap, input int ov_s,
                             input int stall_s, input int stall_len, input string tag);
      int first_sv;
      int ov_before;
      int k;
      first_sv  = cyc;
      ov_before = ov_count;
      for (int s = 0; s < n_sl; s++) begin
         k = TEMP - 1 - s;
         for (int f = 0; f < NUM_FEATURES; f++)
            for (int i = 0; i < SLICE; i++)
               sla_if.features_sliced[f][i] = 8'(x[f][k * SLICE + i]);
         sla_if.slice_valid = 1'b1;
         if (s == 0) first_sv = cyc;
         step();
         sla_if.slice_valid = 1'b0;
         for (int c = 1; c < gap; c++) begin
            if (s == 0 && c == 1) check_val({tag, "_busy_mac"}, sla_if.busy, 1);
            if (c == M + 1 && s != stall_s && s < n_sl - 1)
               check_val({tag, "_busy_wait"}, sla_if.busy, 0);
            if (s == ov_s && c == 3) begin
               for (int f = 0; f < NUM_FEATURES; f++)
                  for (int i = 0; i < SLICE; i++)
                     sla_if.features_sliced[f][i] = 8'($urandom_range(0, 255));
               sla_if.slice_valid = 1'b1;
            end
            if (s == stall_s && c == 3) begin
               sla_if.ce = 1'b0;
               repeat (stall_len) step();
               sla_if.ce = 1'b1;
            end
            step();
            sla_if.slice_valid = 1'b0;
         end
      end
      if (n_sl == TEMP) begin
         repeat (4) step();
         check_val({tag, "_ov_pulses"}, ov_count - ov_before, 1);
         check_val({tag, "_ov_cycle"}, ov_cyc,
                   first_sv + (TEMP - 1) * gap + ((stall_s >= 0) ? stall_len : 0) + M + 2);
         compute_expected();
         for (int f = 0; f < NUM_FEATURES; f++)
            for (int j = 0; j < M; j++)
               check_val($sformatf("%s_r%0d_%0d", tag, f, j), sla_if.result[f][j], exp_r[f][j]);
      end
   endtask

   // Stops a run that never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Test sequence.
   initial begin
      logic any_nz;
      rst = 1'b1;
      sla_if.ce = 1'b1;
      sla_if.slice_valid = 1'b1;
      set_random();
      for (int f = 0; f < NUM_FEATURES; f++)
         for (int i = 0; i < SLICE; i++)
            sla_if.features_sliced[f][i] = 8'($urandom_range(1, 127));
      repeat (3) step();
      any_nz = 1'b0;
      for (int f = 0; f < NUM_FEATURES; f++)
         for (int j = 0; j < M; j++)
            if (sla_if.result[f][j] !== '0) any_nz = 1'b1;
      check_val("rst_result", any_nz, 0);
      check_val("rst_out_valid", sla_if.out_valid, 0);
      check_val("rst_busy", sla_if.busy, 0);
      check_val("rst_overrun", sla_if.overrun, 0);
      rst = 1'b0;
      sla_if.slice_valid = 1'b0;
      step();

      set_unit();
      send_frame(TEMP, M + 1, -1, -1, 0, "unit");
      check_val("unit_overrun", sla_if.overrun, 0);

      for (int f = 0; f < NUM_FEATURES; f++)
         for (int n = 0; n < N; n++) x[f][n] = -1;
      for (int j = 0; j < M; j++) begin
         for (int n = 0; n < N; n++) w[j][n] = 2;
         b[j] = j;
      end
      apply_params();
      send_frame(TEMP, M + 1, -1, -1, 0, "signed");
      check_val("signed_overrun", sla_if.overrun, 0);

      set_unit();
      send_frame(TEMP, M + 1, 1, -1, 0, "ovr");
      check_val("ovr_flag", sla_if.overrun, 1);

      send_frame(TEMP, M + 1, -1, 0, 5, "stall");
      check_val("ovr_sticky", sla_if.overrun, 1);

      rst = 1'b1;
      repeat (2) step();
      check_val("rst2_overrun", sla_if.overrun, 0);
      rst = 1'b0;
      step();
      send_frame(2, M + 1, -1, -1, 0, "part");
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step();
      send_frame(TEMP, M + 1, -1, -1, 0, "after_rst");

      for (int t = 0; t < 4; t++) begin
         int gap;
         int st;
         set_random();
         gap = M + 1 + int'($urandom_range(0, 3));
         st  = (t == 3) ? int'($urandom_range(0, TEMP - 1)) : -1;
         send_frame(TEMP, gap, -1, st, int'($urandom_range(1, 4)), $sformatf("rnd%0d", t));
      end
      check_val("rnd_overrun", sla_if.overrun, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
